phase_accum: RTL and testbench

//   Multi-voice phase accumulator feeding the sine lookup. Holds one frequency word and

---
 rtl/phase_accum_pkg.sv | 30 +++
 rtl/phase_accum_if.sv | 34 +++
 rtl/phase_accum_voice.sv | 56 +++++
 rtl/phase_accum.sv | 84 ++++++++
 tb/tb_phase_accum.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_accum_pkg.sv
// Shared constants and note-command types for the multi-voice phase accumulator
// and the keyboard/score sequencer that drives it.
package phase_accum_pkg;

    localparam int unsigned PLAYER_NUM  = 3;
    localparam int unsigned THETA_WIDTH = 8;
    localparam int unsigned ACC_WIDTH   = 16;
    localparam int unsigned FWORD_WIDTH = 16;

    // Player index width; a single-voice build still carries a 1-bit index.
    function automatic int unsigned pidx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned PIDX_W = pidx_width(PLAYER_NUM);

    typedef enum logic {
        GATE_OFF = 1'b0,
        GATE_ON  = 1'b1
    } gate_e;

    typedef struct packed {
        logic [PIDX_W-1:0]      player;
        gate_e                  gate;
        logic [FWORD_WIDTH-1:0] fword;
    } note_cmd_t;

    localparam int unsigned NOTE_CMD_W = $bits(note_cmd_t);

endpackage

// File: rtl/phase_accum_if.sv
// Note-command valid/ready port between the sequencer (master) and the
// phase accumulator (slave).
interface phase_accum_if
    import phase_accum_pkg::*;
#(
    parameter int unsigned PLAYER_NUM  = phase_accum_pkg::PLAYER_NUM,
    parameter int unsigned FWORD_WIDTH = phase_accum_pkg::FWORD_WIDTH
) ();

    localparam int unsigned PIDX_W = pidx_width(PLAYER_NUM);

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [PIDX_W-1:0]      cmd_player;
    logic                   cmd_gate;
    logic [FWORD_WIDTH-1:0] cmd_fword;

    modport master (
        output cmd_valid,
        output cmd_player,
        output cmd_gate,
        output cmd_fword,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_player,
        input  cmd_gate,
        input  cmd_fword,
        output cmd_ready
    );

endinterface

// File: rtl/phase_accum_voice.sv
// One voice of the accumulator: frequency word, phase accumulator and gate bit.
// theta is the top THETA_WIDTH bits of the accumulator register, so it follows
// the accumulator with no extra pipeline stage.
module phase_voice #(
    parameter int unsigned ACC_WIDTH   = phase_accum_pkg::ACC_WIDTH,
    parameter int unsigned THETA_WIDTH = phase_accum_pkg::THETA_WIDTH,
    parameter int unsigned FWORD_WIDTH = phase_accum_pkg::FWORD_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_i,
    input  logic                   load_on_i,
    input  logic                   load_off_i,
    input  logic [FWORD_WIDTH-1:0] fword_i,
    output logic [THETA_WIDTH-1:0] theta_o,
    output logic                   active_o
);

    logic [ACC_WIDTH-1:0] fword_q, fword_d;
    logic [ACC_WIDTH-1:0] acc_q,   acc_d;
    logic                 active_q, active_d;

    // Next state: a command (note on/off) wins over a tick; inactive voices hold acc at 0.
    always_comb begin
        fword_d  = fword_q;
        acc_d    = acc_q;
        active_d = active_q;
        if (load_on_i) begin
            fword_d  = ACC_WIDTH'(fword_i);
            acc_d    = '0;
            active_d = 1'b1;
        end else if (load_off_i) begin
            acc_d    = '0;
            active_d = 1'b0;
        end else if (tick_i && active_q) begin
            acc_d = acc_q + fword_q;
        end
    end

    // Voice state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fword_q  <= '0;
            acc_q    <= '0;
            active_q <= 1'b0;
        end else begin
            fword_q  <= fword_d;
            acc_q    <= acc_d;
            active_q <= active_d;
        end
    end

    assign theta_o  = acc_q[ACC_WIDTH-1 -: THETA_WIDTH];
    assign active_o = active_q;

endmodule

// File: rtl/phase_accum.sv
// Multi-voice phase accumulator: decodes note commands into per-voice load
// strobes, advances all active voices on each sample tick and publishes the
// packed theta bus for the sine table.
module phase_accum
    import phase_accum_pkg::*;
#(
    parameter int unsigned PLAYER_NUM  = phase_accum_pkg::PLAYER_NUM,
    parameter int unsigned THETA_WIDTH = phase_accum_pkg::THETA_WIDTH,
    parameter int unsigned ACC_WIDTH   = phase_accum_pkg::ACC_WIDTH,
    parameter int unsigned FWORD_WIDTH = phase_accum_pkg::FWORD_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sample_tick,
    phase_accum_if.slave                      cmd,
    output logic [THETA_WIDTH*PLAYER_NUM-1:0] theta,
    output logic                              theta_valid,
    output logic [PLAYER_NUM-1:0]             active
);

    localparam int unsigned PIDX_W = pidx_width(PLAYER_NUM);

    logic                  ready_en_q, ready_en_d;
    logic                  theta_valid_q, theta_valid_d;
    logic                  accept;
    logic [PLAYER_NUM-1:0] load_on;
    logic [PLAYER_NUM-1:0] load_off;

    // Tick has priority over commands, so a command offered in a tick cycle waits one cycle.
    assign cmd.cmd_ready = ready_en_q & ~sample_tick;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;

    // One-hot load decode; an out-of-range player index matches no voice and is dropped.
    always_comb begin
        load_on  = '0;
        load_off = '0;
        for (int unsigned i = 0; i < PLAYER_NUM; i++) begin
            if (accept && (cmd.cmd_player == PIDX_W'(i))) begin
                if (cmd.cmd_gate == GATE_ON) begin
                    load_on[i] = 1'b1;
                end else begin
                    load_off[i] = 1'b1;
                end
            end
        end
    end

    // Next state for the ready enable and the theta_valid strobe.
    always_comb begin
        ready_en_d    = 1'b1;
        theta_valid_d = sample_tick;
    end

    // Control registers: ready held off through reset, theta_valid trails the tick by one clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en_q    <= 1'b0;
            theta_valid_q <= 1'b0;
        end else begin
            ready_en_q    <= ready_en_d;
            theta_valid_q <= theta_valid_d;
        end
    end

    assign theta_valid = theta_valid_q;

    for (genvar v = 0; v < PLAYER_NUM; v++) begin : g_voice
        phase_voice #(
            .ACC_WIDTH   (ACC_WIDTH),
            .THETA_WIDTH (THETA_WIDTH),
            .FWORD_WIDTH (FWORD_WIDTH)
        ) u_voice (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_i     (sample_tick),
            .load_on_i  (load_on[v]),
            .load_off_i (load_off[v]),
            .fword_i    (cmd.cmd_fword),
            .theta_o    (theta[THETA_WIDTH*v +: THETA_WIDTH]),
            .active_o   (active[v])
        );
    end

endmodule

// File: tb/tb_phase_accum.sv
// Directed bench for phase_accum: a reference model predicts theta/active/theta_valid
// for every driven step, expectations are queued and checked one clock later.
module tb_phase_accum;

    logic        clk;
    logic        rst_n;
    logic        sample_tick;
    logic [23:0] theta;
    logic        theta_valid;
    logic [2:0]  active;

    phase_accum_if #(.PLAYER_NUM(3), .FWORD_WIDTH(16)) cmd_if ();

    phase_accum #(
        .PLAYER_NUM  (3),
        .THETA_WIDTH (8),
        .ACC_WIDTH   (16),
        .FWORD_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .cmd         (cmd_if),
        .theta       (theta),
        .theta_valid (theta_valid),
        .active      (active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       tag;
        logic [23:0] theta;
        logic [2:0]  active;
        logic        tv;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [15:0] m_acc [3];
    logic [15:0] m_fw  [3];
    logic [2:0]  m_act;

    function automatic logic [23:0] model_theta();
        logic [23:0] t;
        t = '0;
        for (int i = 0; i < 3; i++) t[8*i +: 8] = m_acc[i][15:8];
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = '0;
            m_fw[i]  = '0;
        end
        m_act = '0;
    endtask

    task automatic model_tick();
        for (int i = 0; i < 3; i++)
            if (m_act[i]) m_acc[i] = m_acc[i] + m_fw[i];
    endtask

    task automatic model_cmd(input int p, input logic g, input logic [15:0] f);
        if (p < 3) begin
            m_acc[p] = '0;
            m_act[p] = g;
            if (g) m_fw[p] = f;
        end
    endtask

    task automatic push_exp(input string tag, input logic tv);
        exp_t e;
        e.tag    = tag;
        e.theta  = model_theta();
        e.active = m_act;
        e.tv     = tv;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%0d entries required>0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert (theta === e.theta) else begin
                n_err++;
                $error("FAIL %s.theta observed=%h expected=%h", e.tag, theta, e.theta);
            end
            n_cmp++;
            assert (active === e.active) else begin
                n_err++;
                $error("FAIL %s.active observed=%b expected=%b", e.tag, active, e.active);
            end
            n_cmp++;
            assert (theta_valid === e.tv) else begin
                n_err++;
                $error("FAIL %s.theta_valid observed=%b expected=%b", e.tag, theta_valid, e.tv);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic do_tick(input string tag);
        sample_tick = 1'b1;
        #1;
        check_val({tag, ".ready_low"}, 32'(cmd_if.cmd_ready), 32'd0);
        @(posedge clk);
        model_tick();
        push_exp(tag, 1'b1);
        #1;
        sample_tick = 1'b0;
        check_out();
    endtask

    task automatic send_cmd(input string tag, input int p, input logic g, input logic [15:0] f);
        int c;
        logic ok;
        c = 0;
        cmd_if.cmd_player = 2'(p);
        cmd_if.cmd_gate   = g;
        cmd_if.cmd_fword  = f;
        cmd_if.cmd_valid  = 1'b1;
        #1;
        while (cmd_if.cmd_ready !== 1'b1 && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        ok = (cmd_if.cmd_ready === 1'b1);
        n_cmp++;
        assert (ok) else begin
            n_err++;
            $error("FAIL %s.ready_timeout observed=%b expected=1", tag, cmd_if.cmd_ready);
        end
        if (ok) begin
            @(posedge clk);
            model_cmd(p, g, f);
            push_exp(tag, 1'b0);
            #1;
            cmd_if.cmd_valid = 1'b0;
            check_out();
        end else begin
            cmd_if.cmd_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        sample_tick       = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_player = '0;
        cmd_if.cmd_gate   = 1'b0;
        cmd_if.cmd_fword  = '0;
        model_reset();

        // 1. reset held three cycles, then released
        repeat (3) @(posedge clk);
        #1;
        push_exp("reset", 1'b0);
        check_out();
        check_val("reset.cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_reset.cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);

        // 2. note on p0, four ticks -> lane0 1,2,3,4
        send_cmd("p0_on", 0, 1'b1, 16'h0100);
        for (int k = 0; k < 4; k++) begin
            do_tick("p0_tick");
            check_val("p0_tick.lane0", 32'(theta[7:0]), 32'(k + 1));
        end
        @(posedge clk);
        #1;
        check_val("idle.theta_valid", 32'(theta_valid), 32'd0);

        // 3. p1 wraps at half scale: 0x80, 0x00, 0x80
        send_cmd("p1_on", 1, 1'b1, 16'h8000);
        do_tick("p1_wrap");
        check_val("p1_wrap.lane1_a", 32'(theta[15:8]), 32'h80);
        do_tick("p1_wrap");
        check_val("p1_wrap.lane1_b", 32'(theta[15:8]), 32'h00);
        do_tick("p1_wrap");
        check_val("p1_wrap.lane1_c", 32'(theta[15:8]), 32'h80);
        check_val("p1_wrap.active1", 32'(active[1]), 32'd1);

        // 4. command offered in a tick cycle stalls one cycle
        cmd_if.cmd_player = 2'd2;
        cmd_if.cmd_gate   = 1'b1;
        cmd_if.cmd_fword  = 16'h0300;
        cmd_if.cmd_valid  = 1'b1;
        sample_tick       = 1'b1;
        #1;
        check_val("stall.ready_in_tick", 32'(cmd_if.cmd_ready), 32'd0);
        @(posedge clk);
        model_tick();
        push_exp("stall_tick", 1'b1);
        #1;
        sample_tick = 1'b0;
        check_out();
        #1;
        check_val("stall.ready_after", 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk);
        model_cmd(2, 1'b1, 16'h0300);
        push_exp("stall_accept", 1'b0);
        #1;
        cmd_if.cmd_valid = 1'b0;
        check_out();
        check_val("stall.lane0_once", 32'(theta[7:0]), 32'h08);
        check_val("stall.lane1_once", 32'(theta[15:8]), 32'h00);

        // 5. note off p0, later ticks keep lane0 at 0; out-of-range player dropped
        send_cmd("p0_off", 0, 1'b0, 16'h0000);
        check_val("p0_off.lane0", 32'(theta[7:0]), 32'h00);
        do_tick("after_off");
        check_val("after_off.lane0_a", 32'(theta[7:0]), 32'h00);
        do_tick("after_off");
        check_val("after_off.lane0_b", 32'(theta[7:0]), 32'h00);
        send_cmd("bad_player", 3, 1'b1, 16'h1234);
        check_val("bad_player.active", 32'(active), 32'b110);

        // 6. three voices, two ticks, then retrigger p1
        send_cmd("tri_p0", 0, 1'b1, 16'h0100);
        send_cmd("tri_p1", 1, 1'b1, 16'h0200);
        send_cmd("tri_p2", 2, 1'b1, 16'h0300);
        do_tick("tri_tick");
        do_tick("tri_tick");
        check_val("tri.theta", 32'(theta), 32'h060402);
        send_cmd("retrig_p1", 1, 1'b1, 16'h0200);
        check_val("retrig.theta", 32'(theta), 32'h060002);
        do_tick("retrig_tick");
        check_val("retrig_tick.theta", 32'(theta), 32'h090203);

        // 7. back-to-back ticks
        sample_tick = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("b2b.ready_low", 32'(cmd_if.cmd_ready), 32'd0);
            @(posedge clk);
            model_tick();
            push_exp("b2b_tick", 1'b1);
            #1;
            check_out();
        end
        sample_tick = 1'b0;
        check_val("b2b.theta", 32'(theta), 32'h120806);

        // 8. gate on with zero frequency word
        send_cmd("zero_fw", 2, 1'b1, 16'h0000);
        do_tick("zero_fw_tick");
        check_val("zero_fw.lane2", 32'(theta[23:16]), 32'h00);
        check_val("zero_fw.active2", 32'(active[2]), 32'd1);

        // 9. reset mid-note with a command pending
        cmd_if.cmd_player = 2'd0;
        cmd_if.cmd_gate   = 1'b1;
        cmd_if.cmd_fword  = 16'h0500;
        cmd_if.cmd_valid  = 1'b1;
        rst_n             = 1'b0;
        @(posedge clk);
        model_reset();
        push_exp("reset_mid_note", 1'b0);
        #1;
        check_out();
        check_val("reset_mid_note.cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
        cmd_if.cmd_valid = 1'b0;
        rst_n            = 1'b1;
        @(posedge clk);
        push_exp("reset_release", 1'b0);
        #1;
        check_out();
        check_val("reset_release.cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
